// File: rtl/led_walker_pkg.sv
// Shared encodings for the LED walker: mode values, one-shot FSM states and
// direction constants used by the top and its bench.
package led_walker_pkg;

    // Operating modes as presented on i_mode; 2'b11 behaves as bounce.
    localparam logic [1:0] MODE_BOUNCE  = 2'b00;
    localparam logic [1:0] MODE_WRAP    = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    // Travel direction of the lit LED.
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // One-shot sweep controller states.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } os_state_e;

endpackage : led_walker_pkg

// File: rtl/walker_strobe_gen.sv
// Reloading down-counter that produces the step strobe for the LED walker.
// The strobe fires on the cycle the counter sits at zero while enabled; the
// counter then reloads so consecutive strobes are STEP_CYCLES apart. A reload
// request wins over everything and parks the counter at STEP_CYCLES-1.
module walker_strobe_gen #(
    parameter int unsigned STEP_CYCLES = 12_000_000
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_en,
    input  logic i_reload,
    output logic o_stb
);

    // One spare bit so STEP_CYCLES-1 always fits, including STEP_CYCLES=1.
    localparam int unsigned CW = $clog2(STEP_CYCLES) + 1;
    localparam logic [CW-1:0] RELOAD_VAL = CW'(STEP_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          at_zero;

    assign at_zero = (cnt_q == '0);

    // Strobe is purely the enabled terminal count.
    always_comb begin
        o_stb = i_en && at_zero;
    end

    // Counter next value: reload first, then count down while enabled, else hold.
    always_comb begin
        cnt_d = cnt_q;
        if (i_reload) begin
            cnt_d = RELOAD_VAL;
        end else if (i_en) begin
            if (at_zero) begin
                cnt_d = RELOAD_VAL;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    // Counter register, parked at the reload value out of reset.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q <= RELOAD_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The counter never leaves the range [0, STEP_CYCLES-1].
    a_cnt_range: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        cnt_q <= RELOAD_VAL);

endmodule : walker_strobe_gen

// File: rtl/led_walker_n.sv
// LED walker top: one lit LED moves across NLEDS outputs at a fixed step rate.
// Bounce, wrap (direction from i_dir) and a triggered one-shot sweep with
// busy/done reporting. Any change of i_mode resynchronises the walker to LED 0.
module led_walker_n
    import led_walker_pkg::*;
#(
    parameter int unsigned NLEDS       = 8,
    parameter int unsigned STEP_CYCLES = 12_000_000
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_run,
    input  logic [1:0]       i_mode,
    input  logic             i_dir,
    input  logic             i_trigger,
    output logic [NLEDS-1:0] o_led,
    output logic             o_step,
    output logic             o_busy,
    output logic             o_done
);

    localparam int unsigned IW = $clog2(NLEDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NLEDS - 1);

    // Registered state.
    logic [IW-1:0] idx_q, idx_d;
    logic          dir_q, dir_d;
    logic          step_q, step_d;
    logic          done_q, done_d;
    logic [1:0]    mode_q;
    os_state_e     state_q, state_d;

    // Control and datapath helpers.
    logic          resync;
    logic          oneshot;
    logic          busy;
    logic          active;
    logic          reload;
    logic          stb;
    logic          fire;
    logic [IW-1:0] bounce_idx;
    logic          bounce_dir;
    logic [IW-1:0] wrap_idx;
    logic          sweep_end;

    // A mode change seen this cycle restarts the walker; it outranks a strobe.
    assign resync  = (mode_q != i_mode);
    assign oneshot = (mode_q == MODE_ONESHOT);
    assign busy    = (state_q == ST_SWEEP);

    // Divider runs when allowed to move; an idle one-shot keeps it parked full.
    assign active = i_run && (!oneshot || busy);
    assign reload = resync || (oneshot && !busy);
    assign fire   = stb && !resync;

    walker_strobe_gen #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_strobe (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_en      (active),
        .i_reload  (reload),
        .o_stb     (stb)
    );

    // Bounce step: turn around at either end so each endpoint shows once.
    always_comb begin
        if (dir_q == DIR_UP) begin
            bounce_idx = (idx_q == LAST_IDX) ? (idx_q - IW'(1)) : (idx_q + IW'(1));
        end else begin
            bounce_idx = (idx_q == '0) ? (idx_q + IW'(1)) : (idx_q - IW'(1));
        end
        bounce_dir = dir_q;
        if (bounce_idx == LAST_IDX) begin
            bounce_dir = DIR_DOWN;
        end else if (bounce_idx == '0) begin
            bounce_dir = DIR_UP;
        end
        // A sweep ends when travelling down and arriving back at LED 0.
        sweep_end = (dir_q == DIR_DOWN) && (bounce_idx == '0);
    end

    // Wrap step: modulo-NLEDS move in the direction sampled at the step.
    always_comb begin
        if (i_dir == DIR_UP) begin
            wrap_idx = (idx_q == LAST_IDX) ? '0 : (idx_q + IW'(1));
        end else begin
            wrap_idx = (idx_q == '0) ? LAST_IDX : (idx_q - IW'(1));
        end
    end

    // Position, direction and pulse next-state.
    always_comb begin
        idx_d  = idx_q;
        dir_d  = dir_q;
        step_d = 1'b0;
        done_d = 1'b0;
        if (resync) begin
            idx_d = '0;
            dir_d = DIR_UP;
        end else if (fire) begin
            step_d = 1'b1;
            if (mode_q == MODE_WRAP) begin
                idx_d = wrap_idx;
            end else begin
                idx_d = bounce_idx;
                dir_d = bounce_dir;
            end
            if (oneshot && sweep_end) begin
                done_d = 1'b1;
            end
        end
    end

    // Datapath registers and the mode sample used to detect mode changes.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            idx_q  <= '0;
            dir_q  <= DIR_UP;
            step_q <= 1'b0;
            done_q <= 1'b0;
            mode_q <= MODE_BOUNCE;
        end else begin
            idx_q  <= idx_d;
            dir_q  <= dir_d;
            step_q <= step_d;
            done_q <= done_d;
            mode_q <= i_mode;
        end
    end

    // One-shot FSM state register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // One-shot FSM next state: start on a running trigger, stop at sweep end.
    always_comb begin
        state_d = state_q;
        if (resync) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (oneshot && i_trigger && i_run) begin
                        state_d = ST_SWEEP;
                    end
                end
                ST_SWEEP: begin
                    if (!oneshot) begin
                        state_d = ST_IDLE;
                    end else if (fire && sweep_end) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // One-shot FSM outputs.
    always_comb begin
        o_busy = busy;
        o_done = done_q;
    end

    // One-hot decode of the registered position plus the step pulse.
    always_comb begin
        o_led  = '0;
        o_step = step_q;
        for (int i = 0; i < int'(NLEDS); i++) begin
            if (idx_q == IW'(i)) begin
                o_led[i] = 1'b1;
            end
        end
    end

    a_onehot: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        $onehot(o_led));
    a_idx_range: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        idx_q <= LAST_IDX);
    a_done_not_busy: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        o_done |-> !o_busy);

endmodule : led_walker_n

// File: tb/tb_led_walker_n.sv
// Bench for led_walker_n: a 4-LED / 3-cycle walker for the mode scenarios and
// a 2-LED / 1-cycle walker for the fastest step rate. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_led_walker_n;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, run, dir, trig;
    logic [1:0] mode;
    logic [3:0] led;
    logic       step, busy, done;

    logic       rst2_n, run2, dir2, trig2;
    logic [1:0] mode2;
    logic [1:0] led2;
    logic       step2, busy2, done2;

    led_walker_n #(.NLEDS(4), .STEP_CYCLES(3)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_run(run), .i_mode(mode),
        .i_dir(dir), .i_trigger(trig), .o_led(led), .o_step(step),
        .o_busy(busy), .o_done(done)
    );

    led_walker_n #(.NLEDS(2), .STEP_CYCLES(1)) dut_fast (
        .i_clk(clk), .i_reset_n(rst2_n), .i_run(run2), .i_mode(mode2),
        .i_dir(dir2), .i_trigger(trig2), .o_led(led2), .o_step(step2),
        .o_busy(busy2), .o_done(done2)
    );

    // ---------------- scoreboard ----------------
    logic [3:0] exp_q[$];
    logic [3:0] exp_v;
    int         total = 0;
    int         bad   = 0;

    // ---------------- driver tasks ----------------
    // Wait up to limit falling edges for a step pulse; report cycles taken.
    task automatic wait_step(input int limit, output int cyc, output bit seen);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (step) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b1; mode = 2'b00; dir = 1'b0; trig = 1'b0;
        rst2_n = 1'b0; run2 = 1'b1; mode2 = 2'b00; dir2 = 1'b0; trig2 = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (led !== 4'b0001) begin bad++; $display("FAIL reset_led: got %b want 0001", led); end
        total++; if (step !== 1'b0) begin bad++; $display("FAIL reset_step: got %b want 0", step); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (led2 !== 2'b01) begin bad++; $display("FAIL reset_led_fast: got %b want 01", led2); end
        rst_n = 1'b1;
    endtask

    task automatic test_bounce();
        int cyc; bit seen;
        exp_q.push_back(4'b0010); exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0100); exp_q.push_back(4'b0010); exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        while (exp_q.size() > 0) begin
            wait_step(10, cyc, seen);
            total++;
            if (!seen) begin bad++; $display("FAIL bounce_timeout: no step in %0d cycles", cyc); exp_q.delete(); break; end
            exp_v = exp_q.pop_front();
            total++; if (cyc != 3) begin bad++; $display("FAIL bounce_gap: got %0d want 3", cyc); end
            total++; if (led !== exp_v) begin bad++; $display("FAIL bounce_led: got %b want %b", led, exp_v); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL bounce_busy: got %b want 0", busy); end
        end
    endtask

    task automatic test_wrap();
        int cyc; bit seen;
        mode = 2'b01; dir = 1'b0;
        @(negedge clk);
        total++; if (led !== 4'b0001) begin bad++; $display("FAIL wrap_resync_led: got %b want 0001", led); end
        total++; if (step !== 1'b0) begin bad++; $display("FAIL wrap_resync_step: got %b want 0", step); end
        for (int phase = 0; phase < 2; phase++) begin
            if (phase == 0) begin
                exp_q.push_back(4'b0010); exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
                exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
                exp_q.push_back(4'b1000);
            end else begin
                dir = 1'b1;
                exp_q.push_back(4'b0100); exp_q.push_back(4'b0010); exp_q.push_back(4'b0001);
                exp_q.push_back(4'b1000);
            end
            while (exp_q.size() > 0) begin
                wait_step(10, cyc, seen);
                total++;
                if (!seen) begin bad++; $display("FAIL wrap_timeout: no step in %0d cycles", cyc); exp_q.delete(); break; end
                exp_v = exp_q.pop_front();
                total++; if (cyc != 3) begin bad++; $display("FAIL wrap_gap: got %0d want 3", cyc); end
                total++; if (led !== exp_v) begin bad++; $display("FAIL wrap_led: got %b want %b", led, exp_v); end
            end
        end
    endtask

    task automatic test_oneshot();
        int cyc; bit seen; int idle_steps;
        mode = 2'b10;
        @(negedge clk);
        total++; if (led !== 4'b0001) begin bad++; $display("FAIL os_resync_led: got %b want 0001", led); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL os_idle_busy: got %b want 0", busy); end
        idle_steps = 0;
        repeat (4) begin @(negedge clk); if (step) idle_steps++; end
        total++; if (idle_steps != 0) begin bad++; $display("FAIL os_idle_steps: got %0d want 0", idle_steps); end
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL os_busy_start: got %b want 1", busy); end
        exp_q.push_back(4'b0010); exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0100); exp_q.push_back(4'b0010); exp_q.push_back(4'b0001);
        while (exp_q.size() > 0) begin
            wait_step(10, cyc, seen);
            total++;
            if (!seen) begin bad++; $display("FAIL os_timeout: no step in %0d cycles", cyc); exp_q.delete(); break; end
            exp_v = exp_q.pop_front();
            total++; if (cyc != 3) begin bad++; $display("FAIL os_gap: got %0d want 3", cyc); end
            total++; if (led !== exp_v) begin bad++; $display("FAIL os_led: got %b want %b", led, exp_v); end
            total++; if (done !== (exp_q.size() == 0)) begin bad++; $display("FAIL os_done: got %b want %b", done, exp_q.size() == 0); end
            total++; if (busy !== (exp_q.size() != 0)) begin bad++; $display("FAIL os_busy: got %b want %b", busy, exp_q.size() != 0); end
        end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL os_done_pulse: got %b want 0", done); end
        idle_steps = 0;
        repeat (6) begin @(negedge clk); if (step) idle_steps++; end
        total++; if (idle_steps != 0) begin bad++; $display("FAIL os_after_steps: got %0d want 0", idle_steps); end
    endtask

    task automatic test_retrigger_pause();
        int cyc; bit seen; int k; int extra; int frozen_bad;
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rp_busy_start: got %b want 1", busy); end
        exp_q.push_back(4'b0010); exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0100); exp_q.push_back(4'b0010); exp_q.push_back(4'b0001);
        k = 0; extra = 0;
        while (exp_q.size() > 0) begin
            wait_step(20, cyc, seen);
            total++;
            if (!seen) begin bad++; $display("FAIL rp_timeout: no step in %0d cycles", cyc); exp_q.delete(); break; end
            exp_v = exp_q.pop_front();
            total++; if (cyc + extra != ((k == 3) ? 8 : 3)) begin bad++; $display("FAIL rp_gap: got %0d want %0d", cyc + extra, (k == 3) ? 8 : 3); end
            total++; if (led !== exp_v) begin bad++; $display("FAIL rp_led: got %b want %b", led, exp_v); end
            total++; if (done !== (exp_q.size() == 0)) begin bad++; $display("FAIL rp_done: got %b want %b", done, exp_q.size() == 0); end
            extra = 0;
            if (k == 1) trig = 1'b1;
            if (k == 2) begin
                trig = 1'b0;
                run = 1'b0;
                frozen_bad = 0;
                repeat (5) begin
                    @(negedge clk);
                    if (step !== 1'b0 || led !== exp_v || busy !== 1'b1) frozen_bad++;
                end
                total++; if (frozen_bad != 0) begin bad++; $display("FAIL rp_frozen: got %0d bad cycles want 0", frozen_bad); end
                run = 1'b1;
                extra = 5;
            end
            k++;
        end
        total++; if (k != 6) begin bad++; $display("FAIL rp_length: got %0d steps want 6", k); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rp_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_rearm();
        int cyc; bit seen;
        trig = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rearm_busy_start: got %b want 1", busy); end
        repeat (6) exp_q.push_back(4'b0000);
        while (exp_q.size() > 0) begin
            wait_step(10, cyc, seen);
            total++;
            if (!seen) begin bad++; $display("FAIL rearm_timeout: no step in %0d cycles", cyc); exp_q.delete(); break; end
            exp_v = exp_q.pop_front();
        end
        total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rearm_done: got done=%b busy=%b want done=1 busy=0", done, busy); end
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rearm_restart: got %b want 1", busy); end
        trig = 1'b0;
    endtask

    task automatic test_mode_change();
        int cyc; bit seen;
        mode = 2'b00;
        @(negedge clk);
        total++; if (led !== 4'b0001 || busy !== 1'b0 || step !== 1'b0) begin bad++; $display("FAIL mc_resync_bounce: got led=%b busy=%b step=%b want 0001/0/0", led, busy, step); end
        exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
        while (exp_q.size() > 0) begin
            wait_step(10, cyc, seen);
            total++;
            if (!seen) begin bad++; $display("FAIL mc_timeout: no step in %0d cycles", cyc); exp_q.delete(); break; end
            exp_v = exp_q.pop_front();
            total++; if (led !== exp_v) begin bad++; $display("FAIL mc_led: got %b want %b", led, exp_v); end
        end
        mode = 2'b01; dir = 1'b0;
        @(negedge clk);
        total++; if (led !== 4'b0001) begin bad++; $display("FAIL mc_led_resync: got %b want 0001", led); end
        total++; if (step !== 1'b0) begin bad++; $display("FAIL mc_step_resync: got %b want 0", step); end
        wait_step(10, cyc, seen);
        total++; if (!seen || cyc != 3) begin bad++; $display("FAIL mc_first_gap: got %0d want 3", cyc); end
        total++; if (led !== 4'b0010) begin bad++; $display("FAIL mc_first_led: got %b want 0010", led); end
    endtask

    task automatic test_async_reset();
        int cyc; bit seen; int pulses;
        mode = 2'b10;
        @(negedge clk);
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        repeat (2) begin
            wait_step(10, cyc, seen);
            total++; if (!seen) begin bad++; $display("FAIL ar_timeout: no step in %0d cycles", cyc); end
        end
        total++; if (led !== 4'b0100 || busy !== 1'b1) begin bad++; $display("FAIL ar_pre: got led=%b busy=%b want 0100/1", led, busy); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (led !== 4'b0001) begin bad++; $display("FAIL ar_led: got %b want 0001", led); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ar_busy: got %b want 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (8) begin @(negedge clk); if (done || step) pulses++; end
        total++; if (pulses != 0) begin bad++; $display("FAIL ar_no_pulse: got %0d want 0", pulses); end
        total++; if (led !== 4'b0001) begin bad++; $display("FAIL ar_idle_led: got %b want 0001", led); end
    endtask

    task automatic test_fast();
        exp_q.push_back(4'b0010); exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010); exp_q.push_back(4'b0001);
        rst2_n = 1'b1;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            exp_v = exp_q.pop_front();
            total++; if ({2'b00, led2} !== exp_v) begin bad++; $display("FAIL fast_led: got %b want %b", led2, exp_v[1:0]); end
            total++; if (step2 !== 1'b1) begin bad++; $display("FAIL fast_step: got %b want 1", step2); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_bounce();
        test_wrap();
        test_oneshot();
        test_retrigger_pause();
        test_rearm();
        test_mode_change();
        test_async_reset();
        test_fast();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_led_walker_n
